// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB-first over WIDTH clocks.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
//
// state | meaning
// ------+---------------------------------------------------
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | one operand bit pair through the full adder per clock
// DONE  | one-cycle done pulse; result valid
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             ha_p, ha_g, fa_s, fa_c;

    always_comb begin
        // Full-adder cell: two half adders and an OR carry merge.
        ha_p = a_sh_q[0] ^ b_sh_q[0];
        ha_g = a_sh_q[0] & b_sh_q[0];
        fa_s = ha_p ^ carry_q;
        fa_c = ha_g | (ha_p & carry_q);

        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Sum bits fill the A shifter from the top as its operand bits drain out the bottom.
                a_sh_d  = {fa_s, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d = fa_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = a_sh_d;
                    cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = carry_q ^ fa_c;
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 and WIDTH=4 instances share clock and reset.
// Checks ovf as well when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8, ovf4;
`endif

    int errors = 0;
    int checks = 0;

    logic [9:0] q8[$];
    logic [5:0] q4[$];
    logic [9:0] exp8;
    logic [5:0] exp4;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf4)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Returns {ovf, cout, sum} for a + b + c.
    function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] t;
        logic       v;
        t = {1'b0, x} + {1'b0, y} + {8'b0, c};
        v = (x[7] == y[7]) && (t[7] != x[7]);
        return {v, t};
    endfunction

    function automatic logic [5:0] model4(input logic [3:0] x, input logic [3:0] y, input logic c);
        logic [4:0] t;
        logic       v;
        t = {1'b0, x} + {1'b0, y} + {4'b0, c};
        v = (x[3] == y[3]) && (t[3] != x[3]);
        return {v, t};
    endfunction

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                chk("sb8_unexpected_done", 32'(done8), 32'd0);
            end else begin
                exp8 = q8.pop_front();
                chk("sum8", 32'(sum8), 32'(exp8[7:0]));
                chk("cout8", 32'(cout8), 32'(exp8[8]));
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf8", 32'(ovf8), 32'(exp8[9]));
`endif
            end
        end
        if (done4) begin
            if (q4.size() == 0) begin
                chk("sb4_unexpected_done", 32'(done4), 32'd0);
            end else begin
                exp4 = q4.pop_front();
                chk("sum4", 32'(sum4), 32'(exp4[3:0]));
                chk("cout4", 32'(cout4), 32'(exp4[4]));
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf4", 32'(ovf4), 32'(exp4[5]));
`endif
            end
        end
    end

    // One operation on the 8-bit instance. inj_k: cycle to pulse a stray start (0 = none).
    // rst_k: cycle to assert reset (0 = none). Cycle k is the k-th falling edge after the accepting edge.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       input int inj_k, input int rst_k,
                       output int done_at, output int busy_n);
        logic [7:0] prev_sum;
        bit         ended;
        done_at  = 0;
        busy_n   = 0;
        ended    = 0;
        @(negedge clk);
        prev_sum = sum8;
        chk("idle_before_start", 32'(busy8), 32'd0);
        start8 = 1'b1;
        a8     = av;
        b8     = bv;
        cin8   = cv;
        q8.push_back(model8(av, bv, cv));
        for (int k = 1; k <= 30 && !ended; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start8 = 1'b0;
                a8     = 8'($urandom);
                b8     = 8'($urandom);
                cin8   = 1'($urandom);
            end
            if (k == inj_k) begin
                start8 = 1'b1;
                a8     = 8'hFF;
                b8     = 8'hFF;
            end
            if (inj_k != 0 && k == inj_k + 1) start8 = 1'b0;
            if (busy8) busy_n++;
            if (done8 && done_at == 0) done_at = k;
            if (k == 4 && rst_k == 0) chk("sum8_hold_during_run", 32'(sum8), 32'(prev_sum));
            if (rst_k != 0 && k == rst_k) begin
                rst = 1'b1;
                q8.delete();
            end
            if (rst_k != 0 && k == rst_k + 1) begin
                chk("abort_busy", 32'(busy8), 32'd0);
                chk("abort_done", 32'(done8), 32'd0);
                chk("abort_sum", 32'(sum8), 32'd0);
                chk("abort_cout", 32'(cout8), 32'd0);
                chk("abort_no_done_pulse", 32'(done_at), 32'd0);
                rst = 1'b0;
            end
            if (!busy8 && !rst) ended = 1;
            if (k == 30) chk("op8_timeout", 32'(ended), 32'd1);
        end
    endtask

    int d_at, b_n, dcount, last_k, first_k;

    initial begin
        rst    = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        // Start held during reset must be overridden.
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_sum", 32'(sum8), 32'd0);
        chk("rst_cout", 32'(cout8), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", 32'(ovf8), 32'd0);
`endif
        start8 = 1'b0;
        rst    = 1'b0;

        op8(8'h5A, 8'h3C, 1'b0, 0, 0, d_at, b_n);
        chk("latency_done_cycle", 32'(d_at), 32'd9);
        chk("latency_busy_cycles", 32'(b_n), 32'd9);

        op8(8'hFF, 8'h01, 1'b0, 0, 0, d_at, b_n);
        op8(8'hFF, 8'h00, 1'b1, 0, 0, d_at, b_n);

        op8(8'h10, 8'h20, 1'b0, 3, 0, d_at, b_n);
        chk("ignored_start_done_cycle", 32'(d_at), 32'd9);

        op8(8'h37, 8'h44, 1'b0, 0, 4, d_at, b_n);
        chk("post_abort_idle", 32'(busy8), 32'd0);
        op8(8'h01, 8'h01, 1'b0, 0, 0, d_at, b_n);
        chk("post_abort_sum", 32'(sum8), 32'h02);

        op8(8'h7F, 8'h01, 1'b0, 0, 0, d_at, b_n);
        op8(8'h80, 8'hFF, 1'b0, 0, 0, d_at, b_n);
        op8(8'h10, 8'h10, 1'b0, 0, 0, d_at, b_n);

        for (int i = 0; i < 6; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom), 0, 0, d_at, b_n);
        end

        // Back-to-back on WIDTH=4 with start held high.
        @(negedge clk);
        a4 = 4'h9; b4 = 4'h9; cin4 = 1'b0; start4 = 1'b1;
        repeat (3) q4.push_back(model4(4'h9, 4'h9, 1'b0));
        dcount  = 0;
        last_k  = 0;
        first_k = 0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (done4) begin
                dcount++;
                if (last_k != 0) chk("b2b_period", 32'(k - last_k), 32'd6);
                else first_k = k;
                last_k = k;
            end
        end
        start4 = 1'b0;
        repeat (2) @(negedge clk);
        chk("b2b_first_done", 32'(first_k), 32'd5);
        chk("b2b_done_count", 32'(dcount), 32'd3);
        chk("b2b_idle_after", 32'(busy4), 32'd0);
        chk("b2b_hold_sum", 32'(sum4), 32'h2);
        chk("b2b_hold_cout", 32'(cout4), 32'd1);

        repeat (3) @(negedge clk);
        chk("sb8_drained", 32'(q8.size()), 32'd0);
        chk("sb4_drained", 32'(q4.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
